// File: rtl/io_hub_pkg.sv
// Shared register map, control bit positions and status word layout
// for the memory-mapped I/O hub.
package io_hub_pkg;

    localparam logic [7:0] OFF_SPRITE    = 8'h00;
    localparam logic [7:0] OFF_KB_DATA   = 8'h80;
    localparam logic [7:0] OFF_KB_STATUS = 8'h84;
    localparam logic [7:0] OFF_CTRL      = 8'h88;

    localparam int CTRL_IRQ_EN  = 0;
    localparam int CTRL_OVF_CLR = 1;

    typedef struct packed {
        logic [15:0] rsvd_hi;
        logic [7:0]  count;
        logic [4:0]  rsvd_lo;
        logic        overflow;
        logic        full;
        logic        empty;
    } kb_status_t;

endpackage

// File: rtl/scancode_fifo.sv
// Circular FIFO for keyboard scancodes; a push while full is accepted
// only when a pop frees a slot on the same edge.
module scancode_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic [CW-1:0]    count,
    output logic             full,
    output logic             empty
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wptr;
    logic [AW-1:0]    rptr;
    logic             do_pop;
    logic             do_push;

    assign empty   = (count == '0);
    assign full    = (count == CW'(DEPTH));
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign dout    = mem[rptr];

    always_ff @(posedge clk) begin
        if (!reset) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (do_push) wptr <= wptr + 1'b1;
            if (do_pop)  rptr <= rptr + 1'b1;
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wptr] <= din;
    end

endmodule

// File: rtl/io_hub.sv
// Address decode, sprite register bank, keyboard FIFO front-end and
// CPU read-data mux for the memory-mapped I/O window.
module io_hub
    import io_hub_pkg::*;
#(
    parameter int DATA_W      = 32,
    parameter int NUM_SPRITES = 4,
    parameter int FIFO_DEPTH  = 8,
    parameter logic [DATA_W-1:0] IO_BASE = DATA_W'(32'h0000_0400)
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [DATA_W-1:0]             adr,
    input  logic [DATA_W-1:0]             wdata,
    input  logic                          we,
    input  logic                          re,
    input  logic [DATA_W-1:0]             mem_rdata,
    output logic                          mem_we,
    output logic [DATA_W-1:0]             rdata,
    input  logic [7:0]                    kb_code,
    input  logic                          kb_valid,
    output logic [NUM_SPRITES*DATA_W-1:0] sprite_regs,
    output logic                          kb_irq
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    logic              io_sel;
    logic [7:0]        off;
    logic [4:0]        sidx;
    logic              hit_spr;
    logic              hit_kbd;
    logic              hit_stat;
    logic              hit_ctrl;
    logic              wr;
    logic              pop;
    logic [7:0]        fifo_dout;
    logic [CW-1:0]     fifo_count;
    logic              fifo_full;
    logic              fifo_empty;
    logic              irq_en_q;
    logic              ovf_q;
    logic              ovf_set;
    logic              ovf_clr;
    logic [DATA_W-1:0] io_rd;
    kb_status_t        status;
    logic              unused_lanes;

    assign unused_lanes = ^adr[1:0];

    assign io_sel = (adr[DATA_W-1:8] == IO_BASE[DATA_W-1:8]);
    assign off    = {adr[7:2], 2'b00};
    assign sidx   = adr[6:2];

    assign hit_spr  = io_sel & ~adr[7] & (int'(sidx) < NUM_SPRITES);
    assign hit_kbd  = io_sel & (off == OFF_KB_DATA);
    assign hit_stat = io_sel & (off == OFF_KB_STATUS);
    assign hit_ctrl = io_sel & (off == OFF_CTRL);

    assign wr     = we & io_sel;
    assign mem_we = we & ~io_sel;
    assign pop    = re & hit_kbd & ~fifo_empty;

    scancode_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (kb_valid),
        .pop   (pop),
        .din   (kb_code),
        .dout  (fifo_dout),
        .count (fifo_count),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // A fresh overflow on the same edge as a clear must survive.
    assign ovf_set = kb_valid & fifo_full & ~pop;
    assign ovf_clr = wr & hit_ctrl & wdata[CTRL_OVF_CLR];

    always_ff @(posedge clk) begin
        if (!reset) begin
            sprite_regs <= '0;
            irq_en_q    <= 1'b0;
            ovf_q       <= 1'b0;
        end else begin
            if (wr & hit_spr)
                sprite_regs[int'(sidx)*DATA_W +: DATA_W] <= wdata;
            if (wr & hit_ctrl)
                irq_en_q <= wdata[CTRL_IRQ_EN];
            ovf_q <= ovf_set | (ovf_q & ~ovf_clr);
        end
    end

    assign kb_irq = irq_en_q & ~fifo_empty;

    always_comb begin
        status          = '0;
        status.count    = 8'(fifo_count);
        status.overflow = ovf_q;
        status.full     = fifo_full;
        status.empty    = fifo_empty;
    end

    always_comb begin
        io_rd = '0;
        unique case (1'b1)
            hit_spr:  io_rd = sprite_regs[int'(sidx)*DATA_W +: DATA_W];
            hit_kbd:  io_rd = fifo_empty ? '0 : DATA_W'(fifo_dout);
            hit_stat: io_rd = DATA_W'(status);
            hit_ctrl: io_rd[CTRL_IRQ_EN] = irq_en_q;
            default:  io_rd = '0;
        endcase
    end

    assign rdata = io_sel ? io_rd : mem_rdata;

endmodule

// File: tb/tb_io_hub.sv
// Self-checking bench for io_hub: queue-based reference model checked
// every cycle, directed register-map scenarios, then random traffic.
module tb_io_hub;

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic [31:0]  adr = '0;
    logic [31:0]  wdata = '0;
    logic         we = 1'b0;
    logic         re = 1'b0;
    logic [31:0]  mem_rdata = '0;
    logic         mem_we;
    logic [31:0]  rdata;
    logic [7:0]   kb_code = '0;
    logic         kb_valid = 1'b0;
    logic [127:0] sprite_regs;
    logic         kb_irq;

    io_hub dut (
        .clk         (clk),
        .reset       (reset),
        .adr         (adr),
        .wdata       (wdata),
        .we          (we),
        .re          (re),
        .mem_rdata   (mem_rdata),
        .mem_we      (mem_we),
        .rdata       (rdata),
        .kb_code     (kb_code),
        .kb_valid    (kb_valid),
        .sprite_regs (sprite_regs),
        .kb_irq      (kb_irq)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    bit chk_en = 1'b0;

    logic [31:0] m_spr [4];
    logic [7:0]  q [$];
    bit          m_irq_en;
    bit          m_ovf;

    task automatic chk(string nm, logic [127:0] act, logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s got %0h want %0h", nm, act, exp);
        end
    endtask

    function automatic logic [31:0] exp_rd();
        logic [7:0] o;
        if (adr[31:8] != 24'h4) return mem_rdata;
        o = {adr[7:2], 2'b00};
        if (o < 8'h10) return m_spr[o[3:2]];
        if (o == 8'h80) return (q.size() > 0) ? {24'b0, q[0]} : 32'h0;
        if (o == 8'h84)
            return {16'b0, 8'(q.size()), 5'b0, m_ovf,
                    q.size() == 8, q.size() == 0};
        if (o == 8'h88) return {31'b0, m_irq_en};
        return 32'h0;
    endfunction

    task automatic drive(logic [31:0] a, logic [31:0] d, logic w,
                         logic r, logic [7:0] kc, logic kv, logic rs);
        @(negedge clk);
        adr = a; wdata = d; we = w; re = r;
        kb_code = kc; kb_valid = kv; reset = rs;
        mem_rdata = $urandom;
        #1;
        if (chk_en) begin
            chk("rdata", rdata, exp_rd());
            chk("mem_we", mem_we, we && adr[31:8] != 24'h4);
            chk("kb_irq", kb_irq, m_irq_en && q.size() > 0);
            chk("sprite", sprite_regs,
                {m_spr[3], m_spr[2], m_spr[1], m_spr[0]});
        end
    endtask

    task automatic io(logic [31:0] a, logic [31:0] d, logic w,
                      logic r, logic [7:0] kc, logic kv);
        drive(a, d, w, r, kc, kv, 1'b1);
    endtask

    task automatic tick();
        bit         sel;
        bit         set;
        bit         clr;
        logic [7:0] o;
        @(posedge clk);
        if (!reset) begin
            foreach (m_spr[i]) m_spr[i] = '0;
            q.delete();
            m_irq_en = 1'b0;
            m_ovf = 1'b0;
            return;
        end
        sel = (adr[31:8] == 24'h4);
        o = {adr[7:2], 2'b00};
        set = 1'b0;
        clr = 1'b0;
        if (we && sel) begin
            if (o < 8'h10) m_spr[o[3:2]] = wdata;
            if (o == 8'h88) begin
                m_irq_en = wdata[0];
                clr = wdata[1];
            end
        end
        if (re && sel && o == 8'h80 && q.size() > 0) void'(q.pop_front());
        if (kb_valid) begin
            if (q.size() < 8) q.push_back(kb_code);
            else set = 1'b1;
        end
        m_ovf = set | (m_ovf & !clr);
    endtask

    initial begin
        logic [31:0] a;
        drive(0, 0, 0, 0, 0, 0, 1'b0); tick();
        drive(0, 0, 0, 0, 0, 0, 1'b0); tick();
        chk_en = 1'b1;

        io(32'h400, 0, 0, 1, 0, 0); chk("rst_spr0", rdata, 32'h0); tick();
        io(32'h480, 0, 0, 1, 0, 0); chk("rst_kbd", rdata, 32'h0); tick();
        io(32'h484, 0, 0, 1, 0, 0); chk("rst_stat", rdata, 32'h1); tick();
        io(32'h488, 0, 0, 1, 0, 0); chk("rst_ctrl", rdata, 32'h0); tick();
        io(32'h10, 32'h55, 1, 1, 0, 0);
        chk("mem_we_lit", mem_we, 1'b1);
        chk("mem_pass", rdata, mem_rdata);
        tick();

        io(32'h40C, 32'hDEAD_0123, 1, 0, 0, 0); tick();
        io(32'h0, 0, 0, 0, 0, 0);
        chk("spr3_lit", sprite_regs[127:96], 32'hDEAD_0123);
        chk("spr_rest", sprite_regs[95:0], 96'h0);
        tick();
        io(32'h410, 32'hFFFF, 1, 0, 0, 0); tick();
        io(32'h410, 0, 0, 1, 0, 0); chk("spr4_rd", rdata, 32'h0); tick();

        io(0, 0, 0, 0, 8'h1C, 1); tick();
        io(0, 0, 0, 0, 8'h32, 1); tick();
        io(0, 0, 0, 0, 8'h21, 1); tick();
        io(32'h484, 0, 0, 1, 0, 0); chk("stat3", rdata, 32'h300); tick();
        io(32'h480, 0, 0, 1, 0, 0); chk("pop1", rdata, 32'h1C); tick();
        io(32'h480, 0, 0, 1, 0, 0); chk("pop2", rdata, 32'h32); tick();
        io(32'h480, 0, 0, 1, 0, 0); chk("pop3", rdata, 32'h21); tick();
        io(32'h480, 0, 0, 1, 0, 0); chk("pop_empty", rdata, 32'h0); tick();
        io(32'h484, 0, 0, 1, 0, 0); chk("stat_e", rdata, 32'h1); tick();

        for (int i = 0; i < 9; i++) begin
            io(0, 0, 0, 0, 8'h40 + 8'(i), 1); tick();
        end
        io(32'h484, 0, 0, 1, 0, 0); chk("stat_ovf", rdata, 32'h806); tick();
        io(32'h488, 32'h2, 1, 0, 0, 0); tick();
        io(32'h484, 0, 0, 1, 0, 0); chk("stat_clr", rdata, 32'h802); tick();

        io(32'h480, 0, 0, 1, 8'h77, 1); chk("full_pp", rdata, 32'h40); tick();
        io(32'h484, 0, 0, 1, 0, 0); chk("stat_pp", rdata, 32'h802); tick();
        for (int i = 0; i < 7; i++) begin
            io(32'h480, 0, 0, 1, 0, 0); tick();
        end
        io(32'h480, 0, 0, 1, 0, 0); chk("last77", rdata, 32'h77); tick();

        io(32'h488, 32'h1, 1, 0, 0, 0); tick();
        io(0, 0, 0, 0, 8'h5A, 1); tick();
        io(0, 0, 0, 0, 0, 0); chk("irq_on", kb_irq, 1'b1); tick();
        io(32'h480, 0, 0, 1, 0, 0); tick();
        io(0, 0, 0, 0, 0, 0); chk("irq_off", kb_irq, 1'b0); tick();
        for (int i = 0; i < 4; i++) begin
            io(0, 0, 0, 0, 8'h10 + 8'(i), 1); tick();
        end
        drive(0, 0, 0, 0, 8'h99, 1, 1'b0); tick();
        io(32'h484, 0, 0, 1, 0, 0);
        chk("rst_flush", rdata, 32'h1);
        chk("rst_irq", kb_irq, 1'b0);
        tick();

        for (int i = 0; i < 4000; i++) begin
            case ($urandom_range(0, 3))
                0: a = $urandom;
                1: a = 32'h400 | 32'($urandom_range(0, 35) << 2)
                       | 32'($urandom_range(0, 3));
                2: a = 32'h480;
                default: a = ($urandom_range(0, 1) != 0) ? 32'h484 : 32'h488;
            endcase
            drive(a, $urandom, $urandom_range(0, 3) == 0,
                  $urandom_range(0, 1) == 1, 8'($urandom),
                  $urandom_range(0, 9) < 4,
                  $urandom_range(0, 299) != 0);
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/io_hub.md
Name: io_hub

Overview:
Parametrised memory-mapped I/O hub between the single-cycle processor's data port, the data memory, the PS/2 keyboard and the VGA sprite logic. It provides:
- Address decode, replacing the fixed decoder.
- A bank of NUM_SPRITES sprite/position registers, replacing the single sprite register.
- A scancode FIFO with status and an interrupt line, so keypresses are no longer lost or hard-wired.
- The final read-data mux back to the CPU.

Parameters:
DATA_W, 32, data and address width.
NUM_SPRITES, 4, number of writable sprite registers (1..32).
FIFO_DEPTH, 8, keyboard FIFO entries (power of two, 2..64).
IO_BASE, 32'h0000_0400, byte base of the 256-byte I/O window (256-aligned).

Ports:
clk  input  1  system clock
reset  input  1  synchronous active-low reset
adr  input  DATA_W  CPU data address (byte)
wdata  input  DATA_W  CPU write data
we  input  1  CPU write strobe
re  input  1  CPU read strobe (load in current cycle)
mem_rdata  input  DATA_W  data memory read data
mem_we  output  1  gated write enable to data memory
rdata  output  DATA_W  read data to CPU
kb_code  input  8  scancode from keyboard receiver
kb_valid  input  1  one-cycle strobe: kb_code is new
sprite_regs  output  NUM_SPRITES*DATA_W  sprite registers, reg i at bits [i*DATA_W +: DATA_W]
kb_irq  output  1  level interrupt: FIFO non-empty and IRQ enabled

Behaviour:
- Clock and reset: one clock, clk. reset is synchronous, active-low, and sampled on the rising edge of clk.
- Reset state: all sprite_regs 0, FIFO empty, count 0, overflow 0, ctrl 0, kb_irq 0.
  - mem_we and rdata are combinational: they follow decode even during reset.
- Decode:
  - io_sel = (adr[DATA_W-1:8] == IO_BASE[DATA_W-1:8]); off = adr[7:0].
  - mem_we = we & ~io_sel.
  - Byte lanes adr[1:0] are ignored.
- Register map (off):
  - 0x00+4*i: SPRITE[i], RW, for i < NUM_SPRITES.
  - 0x80: KB_DATA, RO. Returns {24'b0, head}, or 0 if empty.
  - 0x84: KB_STATUS, RO. Returns {count[7:0] at bits 15:8, 5'b0, overflow, full, empty}.
  - 0x88: CTRL, RW. bit0 = irq_en. Writing 1 to bit1 clears overflow; bit1 reads 0.
  - All other offsets: read 0, writes ignored.
- Read path (combinational): rdata = io_sel ? io_read(off) : mem_rdata. Zero latency, valid in the same cycle as adr.
- Writes take effect at the clock edge when we & io_sel. Read-back of a written value is visible from the next cycle.
- FIFO push and pop:
  - push = kb_valid.
  - pop = re & io_sel & (off==0x80) & ~empty.
  - A pop on the same edge as the read advances the head after the CPU has sampled rdata.
  - Pop when empty: no state change.
- FIFO boundary cases:
  - push & pop when full: both occur, count unchanged, no overflow.
  - push & pop when empty: push only. Data is not bypassed to rdata this cycle.
  - push when full without pop: code dropped, overflow set (sticky).
  - Overflow clear and a new overflow on the same edge: the set wins.
- Pointers: wrap modulo FIFO_DEPTH. count width is clog2(FIFO_DEPTH)+1. full = (count==FIFO_DEPTH).
- kb_irq = irq_en & ~empty, registered from state and updated every cycle.
- we and re on the same cycle at the same address: the write is ignored for RO registers. The read is served normally.
- reset asserted mid-stream: FIFO contents are discarded. A kb_valid on the reset edge is dropped.

Decomposition:
- Package io_hub_pkg holds:
  - localparams for the offsets: OFF_SPRITE, OFF_KB_DATA, OFF_KB_STATUS, OFF_CTRL.
  - CTRL bit indices.
  - typedef kb_status_t (packed struct) for the status word layout.
- One sub-module, scancode_fifo (params WIDTH=8, DEPTH), with push/pop/din/dout/count/full/empty and the same synchronous active-low reset. io_hub instantiates it and owns overflow, ctrl, the sprite bank and the decode.

Test Plan:
- Reset, then read 0x400/0x480/0x484/0x488 -> all 0, except KB_STATUS = 0x0000_0001 (empty). Write to 0x00000010 -> mem_we=1; rdata equals mem_rdata.
- Write 0xDEAD_0123 to 0x40C (SPRITE[3]) -> sprite_regs[127:96]=0xDEAD_0123 next cycle, others unchanged. Write to 0x410 (beyond NUM_SPRITES) -> no change, reads 0.
- Push 0x1C, 0x32, 0x21 -> KB_STATUS = 0x0000_0300. Three KB_DATA reads return 0x1C, 0x32, 0x21 in order. A fourth read returns 0, state unchanged, empty=1.
- Push 9 codes with no pops (DEPTH 8) -> full=1, overflow=1, KB_STATUS=0x0000_0806. The 9th code is dropped. Write CTRL=0x2 -> overflow=0.
- With the FIFO full, kb_valid and a KB_DATA read on the same cycle -> count stays 8, overflow stays 0, the oldest code is returned, and the new code is read last.
- CTRL=1, push one code -> kb_irq=1 on the next cycle. Pop it -> kb_irq=0. Assert reset with 4 codes queued -> empty on the next cycle, kb_irq=0.
